if_id_queue: RTL and testbench
==============================

# if_id_queue

Instruction queue between the fetch stage and the decode stage of the ARM pipeline. It stores up to DEPTH fetched (pc, instruction) pairs so that a decode stall does not immediately freeze the PC register. It is flushed on a taken branch. Fetch writes into it with a valid/ready handshake, and decode drains it in order through a first-word-fall-through read port.

## Interface
Parameters:
- BIT_NUMBER, 32, width of pc and instruction.
- DEPTH, 4, number of entries; must be a power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  taken-branch flush, driven by the branch_taken signal.
- in_valid  input  1  fetch presents a new entry.
- in_pc  input  BIT_NUMBER  pc+4 value produced by fetch.
- in_instruction  input  BIT_NUMBER  fetched instruction word.
- in_ready  output  1  queue accepts an entry this cycle; fetch freeze = ~in_ready.
- out_valid  output  1  head entry is valid.
- out_pc  output  BIT_NUMBER  pc of the head entry.
- out_instruction  output  BIT_NUMBER  instruction of the head entry.
- out_ready  input  1  decode consumes the head this cycle (low when hazard or freeze).
- count  output  $clog2(DEPTH+1)  number of stored entries.

## Operation
- Storage: circular buffer of DEPTH entries, with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits. Both pointers wrap modulo DEPTH. count tracks occupancy from 0 to DEPTH.
- Push: occurs when in_valid && in_ready && !flush. The entry is written at wr_ptr, then wr_ptr increments.
- Pop: occurs when out_valid && out_ready && !flush. rd_ptr increments.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- in_ready = (count < DEPTH) && !flush.
  - in_ready does not depend on out_ready, so there is no combinational path from decode to fetch.
  - A full queue refuses a push even in a cycle with a pop.
- out_valid = (count != 0) && !flush.
- out_pc and out_instruction show the entry at rd_ptr. They are forced to 0 whenever out_valid = 0, which decodes as a NOP/bubble.
- Flush: at the next edge, count ← 0 and wr_ptr = rd_ptr ← 0.
  - A concurrent in_valid entry is discarded, not stored.
  - No pop is reported to decode in the flush cycle.
- Reset: same effect as flush, and it takes priority over flush and over any push or pop.
- Flush has priority over push and pop.
- Entries are never reordered, duplicated or dropped except by flush or reset.

## Timing
- Reset values (the cycle after rst is sampled high):
  - count = 0, out_valid = 0, out_pc = 0, out_instruction = 0, in_ready = 1.
  - Pointers are 0.
- Push-to-out latency (no bypass): an entry pushed at edge N is visible on out_* at edge N if it becomes the head, that is, in the cycle after the write.
- Full boundary: when count = DEPTH, in_ready = 0. It returns to 1 in the cycle after the first pop.
- Empty boundary: when count = 0, out_valid = 0 and pop is ignored.
- Wrap-around: the pointer after DEPTH-1 is 0. There is no bubble at the wrap.
- Reset mid-operation: all stored entries are lost, with no partial state left.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined: when count = 0, in_valid = 1 and !flush, the input is shown combinationally on out_*, with out_valid = 1.
  - If out_ready = 1 in that cycle, the entry is consumed directly and not stored, so count stays 0 (zero latency).
  - If out_ready = 0, the entry is pushed normally.
- IF_ID_QUEUE_BYPASS_EN undefined: there is no in-to-out combinational path, and latency is 1 cycle as in Timing.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1 → count = 0, out_valid = 0, out_* = 0, in_ready = 1.
- In-order stream: push pc 4, 8, 12, 16 with out_ready = 0 →
  - count = 4 and in_ready = 0.
  - Raise out_ready: the queue pops in order 4, 8, 12, 16.
  - count then returns to 0 and out_valid falls.
- Full with pop: queue full and in_valid = 1 and out_ready = 1 for 1 cycle → the pop occurs, the push is refused, and count = 3.
  - The next cycle's push is accepted.
- Flush: 3 entries stored, then flush = 1 together with in_valid = 1 → next cycle count = 0 and out_valid = 0.
  - The next pushed entry (pc 0x100) is the head.
- Wrap: 10 back-to-back push/pop cycles with DEPTH = 4 → every pc appears on out_pc exactly once, in order, through pointer wrap.
- Bypass (IF_ID_QUEUE_BYPASS_EN defined): queue empty, in_valid = 1, out_ready = 1, in_pc = 0x20 → out_pc = 0x20 in the same cycle, and count stays 0.
  - Without the macro, out_valid = 0 in that cycle and out_pc = 0x20 appears in the next cycle.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of (pc, instruction), FWFT read, flushed on taken branch.
// Define IF_ID_QUEUE_BYPASS_EN to forward an incoming entry straight to decode when the queue is empty.
module if_id_queue #(
  parameter int BIT_NUMBER = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [BIT_NUMBER-1:0]        in_pc,
  input  logic [BIT_NUMBER-1:0]        in_instruction,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [BIT_NUMBER-1:0]        out_pc,
  output logic [BIT_NUMBER-1:0]        out_instruction,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [BIT_NUMBER-1:0] pc_mem    [DEPTH];
  logic [BIT_NUMBER-1:0] instr_mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  bypass;
  logic                  push;
  logic                  pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // in_ready deliberately ignores out_ready: no decode-to-fetch combinational path.
  assign in_ready = !full && !flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = (!empty || bypass) && !flush;

  always_comb begin
    out_pc          = '0;
    out_instruction = '0;
    if (out_valid) begin
      if (bypass) begin
        out_pc          = in_pc;
        out_instruction = in_instruction;
      end else begin
        out_pc          = pc_mem[rd_ptr];
        out_instruction = instr_mem[rd_ptr];
      end
    end
  end

  // A bypassed entry taken by decode is neither stored nor popped from storage.
  assign push = in_valid && in_ready && !(bypass && out_ready);
  assign pop  = out_valid && out_ready && !bypass;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instruction;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized scoreboard bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  localparam int BN    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [BN-1:0] in_pc, in_instruction, out_pc, out_instruction;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  if_id_queue #(.BIT_NUMBER(BN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instruction(in_instruction), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instruction(out_instruction), .out_ready(out_ready),
    .count(count)
  );

  typedef struct packed { logic [BN-1:0] pc; logic [BN-1:0] ins; } ent_t;
  typedef struct packed { logic [CW-1:0] cnt; logic rdy; logic vld; } st_t;

  ent_t model_q[$];  // entries the queue should hold
  ent_t sb_q[$];     // entries decode should receive, in order
  st_t  st_q[$];     // per-cycle expected status
  int   errors = 0;
  int   checks = 0;
  bit   run = 1'b0;
  st_t  ms;
  ent_t me;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs and records what the queue's rules predict.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [BN-1:0] pc, input logic ordy);
    ent_t e;
    st_t  s;
    bit   byp, acc, pop;
    rst            = r;
    flush          = f;
    in_valid       = iv;
    in_pc          = pc;
    in_instruction = {pc[15:0], pc[31:16]} ^ 32'hE1A0_0000;
    out_ready      = ordy;
    e.pc  = pc;
    e.ins = in_instruction;
    byp   = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
    byp = (model_q.size() == 0) && iv && !f;
`endif
    s.cnt = CW'(model_q.size());
    s.rdy = (model_q.size() < DEPTH) && !f;
    s.vld = ((model_q.size() != 0) || byp) && !f;
    st_q.push_back(s);
    if (s.vld && ordy && !r) sb_q.push_back(byp ? e : model_q[0]);
    if (r || f) begin
      model_q.delete();
    end else begin
      pop = s.vld && ordy && !byp;
      acc = iv && s.rdy && !(byp && ordy);
      if (pop) void'(model_q.pop_front());
      if (acc) model_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (run && st_q.size() != 0) begin
      ms = st_q.pop_front();
      check("count", 64'(count), 64'(ms.cnt));
      check("in_ready", 64'(in_ready), 64'(ms.rdy));
      check("out_valid", 64'(out_valid), 64'(ms.vld));
      if (!out_valid) begin
        check("bubble_pc", 64'(out_pc), 64'd0);
        check("bubble_instruction", 64'(out_instruction), 64'd0);
      end else if (out_ready && !rst) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %0h expected no pop", out_pc);
        end else begin
          me = sb_q.pop_front();
          check("out_pc", 64'(out_pc), 64'(me.pc));
          check("out_instruction", 64'(out_instruction), 64'(me.ins));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instruction = '0;
    @(posedge clk);
    #1;
    run = 1'b1;

    // Reset with in_valid held high
    step(1, 0, 1, 32'h40, 0);
    step(1, 0, 1, 32'h44, 0);

    // In-order stream, then drain
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 32'(4 * i), 0);
    step(0, 0, 1, 32'h99, 0);  // refused while full
    for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 1);

    // Full with simultaneous pop: push refused, next push accepted
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'(32'h200 + 4 * i), 0);
    step(0, 0, 1, 32'h300, 1);
    step(0, 0, 1, 32'h304, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 1);

    // Flush with concurrent push, then a fresh head
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'(32'h400 + 4 * i), 0);
    step(0, 1, 1, 32'h500, 1);
    step(0, 0, 1, 32'h100, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    // Back-to-back push/pop through pointer wrap
    for (int i = 0; i < 10; i++) step(0, 0, 1, 32'(32'h1000 + 4 * i), 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    // Empty queue with push and pop in the same cycle
    step(0, 0, 1, 32'h20, 1);
    step(0, 0, 0, 32'h0, 1);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 250) == 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
           $urandom, ($urandom % 3) != 0);
    end

    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 32'h0, 1);
    @(negedge clk);
    #1;
    run = 1'b0;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("model_drained", 64'(model_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
